// File: rtl/led_breather.sv
// Breathing brightness sequencer for the 4-bit PWM LED dimmer: ramps w up, holds bright,
// ramps down, holds dim, and only ever changes w on 16-clk PWM frame boundaries.
module led_breather #(
    parameter int STEP_FRAMES = 64,
    parameter int HOLD_FRAMES = 256,
    parameter int W_MIN       = 0,
    parameter int W_MAX       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       continuous,
    output logic       en_out,
    output logic [3:0] w,
    output logic       busy,
    output logic       cycle_done,
    output logic [2:0] state_dbg
);

    localparam int MAX_FRAMES = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
    localparam int CW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);
    localparam logic [3:0]    W_LO      = 4'(W_MIN);
    localparam logic [3:0]    W_HI      = 4'(W_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    phase;
    logic [3:0]    phase_next;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] frame_cnt_next;
    logic [3:0]    w_next;
    logic          en_next;
    logic          done_next;
    logic          frame_end;
    logic          step_end;
    logic          hold_end;

    // phase tracks the dimmer's own counter, which also sits at 0 whenever en is low
    assign frame_end = en_out && (phase == 4'd15);
    assign step_end  = frame_end && (frame_cnt == STEP_LAST);
    assign hold_end  = frame_end && (frame_cnt == HOLD_LAST);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_next = S_RISE;
                S_RISE:    if (step_end && (w == W_HI)) state_next = S_HOLD_HI;
                S_HOLD_HI: if (hold_end) state_next = S_FALL;
                S_FALL:    if (step_end && (w == W_LO)) state_next = S_HOLD_LO;
                S_HOLD_LO: if (hold_end) state_next = continuous ? S_RISE : S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_next         = w;
        frame_cnt_next = frame_cnt;
        done_next      = 1'b0;
        if (stop) begin
            w_next         = W_LO;
            frame_cnt_next = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    w_next         = W_LO;
                    frame_cnt_next = '0;
                end
                S_RISE: begin
                    if (step_end) begin
                        frame_cnt_next = '0;
                        if (w != W_HI) w_next = w + 4'd1;
                    end else if (frame_end) begin
                        frame_cnt_next = frame_cnt + CW'(1);
                    end
                end
                S_HOLD_HI: begin
                    w_next = W_HI;
                    if (hold_end) frame_cnt_next = '0;
                    else if (frame_end) frame_cnt_next = frame_cnt + CW'(1);
                end
                S_FALL: begin
                    if (step_end) begin
                        frame_cnt_next = '0;
                        if (w != W_LO) w_next = w - 4'd1;
                    end else if (frame_end) begin
                        frame_cnt_next = frame_cnt + CW'(1);
                    end
                end
                S_HOLD_LO: begin
                    w_next = W_LO;
                    if (hold_end) begin
                        frame_cnt_next = '0;
                        done_next      = 1'b1;
                    end else if (frame_end) begin
                        frame_cnt_next = frame_cnt + CW'(1);
                    end
                end
                default: begin
                    w_next         = W_LO;
                    frame_cnt_next = '0;
                end
            endcase
        end
        en_next = (state_next != S_IDLE);
        // a continuous loop keeps en high, so the phase carries on across the breath boundary
        phase_next = (en_next && en_out) ? phase + 4'd1 : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_out     <= 1'b0;
            busy       <= 1'b0;
            w          <= W_LO;
            cycle_done <= 1'b0;
            phase      <= 4'd0;
            frame_cnt  <= '0;
        end else begin
            en_out     <= en_next;
            busy       <= en_next;
            w          <= w_next;
            cycle_done <= done_next;
            phase      <= phase_next;
            frame_cnt  <= frame_cnt_next;
        end
    end

endmodule

// File: tb/tb_led_breather.sv
// Bench for led_breather: a short-profile instance for sequencing corner cases and a
// default-profile instance for a full breath with frame-alignment tracking.
module tb_led_breather;

    localparam int EW = 7;  // {en_out, busy, cycle_done, w[3:0]}

    localparam int A_STEP = 1;
    localparam int A_HOLD = 1;
    localparam int A_WMIN = 0;
    localparam int A_WMAX = 3;
    localparam int B_STEP = 64;
    localparam int B_HOLD = 256;
    localparam int B_WMIN = 0;
    localparam int B_WMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, stop_a = 1'b0, cont_a = 1'b0;
    logic start_b = 1'b0, stop_b = 1'b0, cont_b = 1'b0;
    logic       en_a, busy_a, done_a, en_b, busy_b, done_b;
    logic [3:0] w_a, w_b;
    logic [2:0] state_a, state_b;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_b_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [3:0] ph_b = 4'd0;
    logic       prev_en_b = 1'b0;
    logic [3:0] w_b_prev = 4'd0;

    led_breather #(.STEP_FRAMES(A_STEP), .HOLD_FRAMES(A_HOLD), .W_MIN(A_WMIN), .W_MAX(A_WMAX)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .continuous(cont_a),
        .en_out(en_a), .w(w_a), .busy(busy_a), .cycle_done(done_a), .state_dbg(state_a)
    );

    led_breather #(.STEP_FRAMES(B_STEP), .HOLD_FRAMES(B_HOLD), .W_MIN(B_WMIN), .W_MAX(B_WMAX)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .continuous(cont_b),
        .en_out(en_b), .w(w_b), .busy(busy_b), .cycle_done(done_b), .state_dbg(state_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic push_frame(input bit to_b, input int lv, input bit first_done);
        logic [EW-1:0] e;
        for (int c = 0; c < 16; c++) begin
            e = {1'b1, 1'b1, 1'(first_done && (c == 0)), 4'(lv)};
            if (to_b) exp_b_q.push_back(e);
            else exp_q.push_back(e);
        end
    endtask

    task automatic push_breath(input bit to_b, input bit first_done);
        int wmin, wmax, step, hold;
        bit fd;
        wmin = to_b ? B_WMIN : A_WMIN;
        wmax = to_b ? B_WMAX : A_WMAX;
        step = to_b ? B_STEP : A_STEP;
        hold = to_b ? B_HOLD : A_HOLD;
        fd = first_done;
        for (int lv = wmin; lv <= wmax; lv++)
            for (int f = 0; f < step; f++) begin
                push_frame(to_b, lv, fd);
                fd = 1'b0;
            end
        for (int f = 0; f < hold; f++) push_frame(to_b, wmax, 1'b0);
        for (int lv = wmax; lv >= wmin; lv--)
            for (int f = 0; f < step; f++) push_frame(to_b, lv, 1'b0);
        for (int f = 0; f < hold; f++) push_frame(to_b, wmin, 1'b0);
    endtask

    task automatic push_done(input bit to_b);
        if (to_b) exp_b_q.push_back({1'b0, 1'b0, 1'b1, 4'(B_WMIN)});
        else exp_q.push_back({1'b0, 1'b0, 1'b1, 4'(A_WMIN)});
    endtask

    // scoreboard: advance n clocks, comparing both instances against their expected queues
    task automatic run_cycles(input int n);
        logic [EW-1:0] ea, eb;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            ea = (exp_q.size() > 0) ? exp_q.pop_front() : {3'b000, 4'(A_WMIN)};
            eb = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : {3'b000, 4'(B_WMIN)};
            checks++;
            assert ({en_a, busy_a, done_a, w_a} === ea) else begin
                errors++;
                $error("FAIL dut_a_trace t=%0d en/busy/done/w got %b required %b",
                       cyc, {en_a, busy_a, done_a, w_a}, ea);
            end
            checks++;
            assert ({en_b, busy_b, done_b, w_b} === eb) else begin
                errors++;
                $error("FAIL dut_b_trace t=%0d en/busy/done/w got %b required %b",
                       cyc, {en_b, busy_b, done_b, w_b}, eb);
            end
            ph_b = (eb[6] && prev_en_b) ? ph_b + 4'd1 : 4'd0;
            prev_en_b = eb[6];
            if (w_b !== w_b_prev) begin
                checks++;
                assert (ph_b === 4'd0) else begin
                    errors++;
                    $error("FAIL w_alignment t=%0d w changed at phase %0d required 0", cyc, ph_b);
                end
            end
            w_b_prev = w_b;
        end
    endtask

    task automatic check_idle_state(input string tag);
        checks++;
        assert (state_a === 3'd0) else begin
            errors++;
            $error("FAIL %s state_a got %0d required 0", tag, state_a);
        end
        checks++;
        assert (state_b === 3'd0) else begin
            errors++;
            $error("FAIL %s state_b got %0d required 0", tag, state_b);
        end
    endtask

    initial begin
        // reset values
        rst = 1'b1;
        run_cycles(2);
        check_idle_state("reset");
        rst = 1'b0;
        run_cycles(3);

        // one-shot breath: done and en low at cycle 160
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        push_done(1'b0);
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(160);
        run_cycles(3);

        // continuous: done at 160, 320, then one-shot finish at 480
        cont_a = 1'b1;
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        push_breath(1'b0, 1'b1);
        push_breath(1'b0, 1'b1);
        push_done(1'b0);
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(399);
        cont_a = 1'b0;
        run_cycles(81);
        run_cycles(3);

        // abort at cycle 50 during RISE, then clean restart
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(50);
        stop_a = 1'b1;
        exp_q.delete();
        run_cycles(1);
        stop_a = 1'b0;
        check_idle_state("abort");
        run_cycles(3);
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        push_done(1'b0);
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(160);
        run_cycles(2);

        // start and stop together in IDLE: stop wins
        start_a = 1'b1;
        stop_a = 1'b1;
        run_cycles(2);
        start_a = 1'b0;
        stop_a = 1'b0;
        run_cycles(2);

        // start pulses while busy are ignored
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        push_done(1'b0);
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(20);
        start_a = 1'b1;
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(50);
        start_a = 1'b1;
        run_cycles(3);
        start_a = 1'b0;
        run_cycles(86);
        run_cycles(2);

        // stop coincident with HOLD_LO hold end: no cycle_done
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(159);
        stop_a = 1'b1;
        exp_q.delete();
        run_cycles(1);
        stop_a = 1'b0;
        run_cycles(3);

        // start held high in one-shot mode re-triggers one cycle after IDLE entry
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        push_done(1'b0);
        push_breath(1'b0, 1'b0);
        push_done(1'b0);
        run_cycles(162);
        start_a = 1'b0;
        run_cycles(160);
        run_cycles(2);

        // reset during HOLD_HI, then only a new start resumes
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(70);
        rst = 1'b1;
        exp_q.delete();
        run_cycles(1);
        rst = 1'b0;
        check_idle_state("mid_reset");
        run_cycles(5);
        start_a = 1'b1;
        push_breath(1'b0, 1'b0);
        push_done(1'b0);
        run_cycles(1);
        start_a = 1'b0;
        run_cycles(160);
        run_cycles(2);

        // full default-profile breath on the second instance
        start_b = 1'b1;
        push_breath(1'b1, 1'b0);
        push_done(1'b1);
        run_cycles(1);
        start_b = 1'b0;
        run_cycles(40960);
        run_cycles(3);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
